calc_token_parser: RTL and testbench
====================================

# calc_token_parser

Downstream consumer of the UART byte receiver in the calculator datapath. Takes the one-cycle `rx_vld`/`rx_data` byte stream and converts ASCII characters into tokens for the expression evaluator: decimal operands, operators, and the terminator `=`. Tokens leave on a valid/ready interface with a one-entry output register. The `ovf` flag reports bytes lost to evaluator back-pressure.

## Interface
- `W`, 32: operand width in bits; unsigned, minimum 8.
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `rx_vld`  in  1  one-cycle strobe; `rx_data` is valid while it is high.
- `rx_data`  in  8  received ASCII byte.
- `tok_vld`  out  1  token valid; held until accepted.
- `tok_rdy`  in  1  evaluator accepts the token in any cycle where `tok_vld && tok_rdy`.
- `tok_type`  out  2  token type: 0 NUM, 1 OP, 2 EQ, 3 ERR.
- `tok_data`  out  W  token payload:
  - NUM: the operand value.
  - OP: the operator's ASCII code, zero-extended.
  - EQ: 0.
  - ERR: the offending byte, zero-extended.
- `tok_sat`  out  1  NUM token only: the operand exceeded 2^W−1 during accumulation.
- `ovf`  out  1  sticky: a byte was dropped. Cleared only by `rst`.

## Operation
- States:
  - S_IDLE: no operand in progress.
  - S_NUM: accumulating digits.
  - S_PEND: a second token is queued behind the currently presented one.
- Byte classes:
  - Digit `0x30–0x39`:
    - In S_IDLE: `acc = d`, go to S_NUM.
    - In S_NUM: `acc = acc*10 + d`.
    - No token is emitted.
  - Operator `+ - * /` (0x2B, 0x2D, 0x2A, 0x2F):
    - In S_NUM: emit NUM(acc), queue OP, go to S_PEND.
    - In S_IDLE: emit OP directly.
  - Terminator `=` (0x3D) or CR (0x0D):
    - In S_NUM: emit NUM, queue EQ.
    - In S_IDLE: emit EQ.
  - Delimiter space (0x20) or LF (0x0A):
    - In S_NUM: emit NUM, go to S_IDLE.
    - In S_IDLE: ignored.
  - Any other byte: emit ERR(byte), discard `acc`, go to S_IDLE. A partial operand is not emitted.
- Leaving S_PEND: when the first token is accepted, the queued token is presented and the state returns to S_IDLE.
- Arithmetic:
  - `acc*10` is computed as `(acc<<3)+(acc<<1)`, plus `d`, in W+4 bits.
  - Overflow is any nonzero bit above bit W−1. Overflow sets an internal sat bit, which is copied to `tok_sat` on the NUM token.
- Busy rule: a byte arriving while `tok_vld && !tok_rdy`, or while in S_PEND, is dropped. `ovf` is set, and state and `acc` are unchanged.
  - A byte arriving in the same cycle as an accepting handshake, with no token queued, is processed normally.
- Reset values:
  - `tok_vld=0`, `tok_type=0`, `tok_data=0`, `tok_sat=0`, `ovf=0`.
  - State S_IDLE, `acc=0`, sat bit cleared.
- Reset mid-operand discards the operand. No token is emitted.

## Timing
- `rx_vld` in cycle n → `tok_vld` high in cycle n+1, with all token fields registered.
- Queued token: `tok_vld` stays high with the new fields in the cycle after the accepting handshake. There are no bubbles between the two tokens.
- Digit accumulation takes 1 cycle per byte. There is no combinational path from `rx_data` to any output.
- Output fields are stable while `tok_vld && !tok_rdy`.
- At 115200 bps, bytes arrive at ≥ 8680-cycle spacing. The evaluator must accept within that window to avoid `ovf`.

## Configuration
- `CALC_PARSE_SAT_EN` defined:
  - On overflow, `acc` clamps to 2^W−1 and further digits keep it clamped.
  - The NUM token carries `tok_sat=1`.
- `CALC_PARSE_SAT_EN` undefined:
  - `acc` wraps modulo 2^W.
  - `tok_sat` still reports that overflow occurred.

## Structure
- Shared package `calc_pkg`:
  - Token type constants `TOK_NUM`, `TOK_OP`, `TOK_EQ`, `TOK_ERR`.
  - ASCII constants for the digits, the operators, `=`, CR, LF and space.
  - Parser state encoding.
- Sub-module `dec_acc`:
  - Combinational multiply-by-10-add.
  - Inputs: `acc`, digit. Outputs: next `acc`, overflow.
  - Owns the saturate-or-wrap selection under `CALC_PARSE_SAT_EN`.

## Test plan
- "12+3=" with `tok_rdy=1` → tokens NUM 12, OP 0x2B, NUM 3, EQ. NUM/OP and NUM/EQ pairs are back-to-back; `ovf=0`.
- "7*8 " with `tok_rdy` held low for 20 cycles after each token → tokens NUM 7, OP 0x2A, NUM 8. Fields are stable while stalled; `ovf=0`.
- `W=8`, "300 " → with `CALC_PARSE_SAT_EN`: NUM 255, `tok_sat=1`. Without it: NUM 44, `tok_sat=1`.
- "4x5=" → tokens ERR 0x78, NUM 5, EQ. The 4 is discarded.
- Token stalled (`tok_rdy=0`) while a byte '9' arrives → '9' is dropped, `ovf=1` and stays high until `rst`.
- Reset asserted after "12", then "5=" → tokens NUM 5, EQ. All outputs are 0 during reset.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the calculator datapath: token types, ASCII codes, parser state encoding
// and a byte classifier used by the token parser.
package calc_pkg;

    localparam logic [1:0] TOK_NUM = 2'd0;
    localparam logic [1:0] TOK_OP  = 2'd1;
    localparam logic [1:0] TOK_EQ  = 2'd2;
    localparam logic [1:0] TOK_ERR = 2'd3;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SP    = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NUM  = 2'd1,
        S_PEND = 2'd2
    } parse_state_t;

    typedef enum logic [2:0] {
        CLS_DIGIT,
        CLS_OP,
        CLS_TERM,
        CLS_DELIM,
        CLS_OTHER
    } byte_class_t;

    function automatic byte_class_t classify(input logic [7:0] b);
        if (b >= ASCII_0 && b <= ASCII_9) begin
            return CLS_DIGIT;
        end else if (b == ASCII_PLUS || b == ASCII_MINUS || b == ASCII_STAR
                     || b == ASCII_SLASH) begin
            return CLS_OP;
        end else if (b == ASCII_EQ || b == ASCII_CR) begin
            return CLS_TERM;
        end else if (b == ASCII_SP || b == ASCII_LF) begin
            return CLS_DELIM;
        end
        return CLS_OTHER;
    endfunction

endpackage

// File: rtl/dec_acc.sv
// Combinational decimal accumulate step: acc*10 + digit with overflow detection.
// CALC_PARSE_SAT_EN selects clamping to all-ones on overflow; otherwise the result wraps.
module dec_acc #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] acc,
    input  logic [3:0]   digit,
    output logic [W-1:0] acc_next,
    output logic         ovf
);

    logic [W+3:0] wide;

    always_comb begin
        // acc*10 as two shifts; four extra bits hold any product of a W-bit value and 10
        wide = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{W{1'b0}}, digit};
        ovf  = |wide[W+3:W];
`ifdef CALC_PARSE_SAT_EN
        acc_next = ovf ? '1 : wide[W-1:0];
`else
        acc_next = wide[W-1:0];
`endif
    end

endmodule

// File: rtl/calc_token_parser.sv
// ASCII byte stream to calculator tokens (NUM/OP/EQ/ERR) on a valid/ready output register.
// Overflow handling of operands is selected by CALC_PARSE_SAT_EN (see dec_acc).
module calc_token_parser
    import calc_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_vld,
    input  logic [7:0]   rx_data,
    output logic         tok_vld,
    input  logic         tok_rdy,
    output logic [1:0]   tok_type,
    output logic [W-1:0] tok_data,
    output logic         tok_sat,
    output logic         ovf
);

    parse_state_t state_q, state_d;
    byte_class_t  cls;
    logic [W-1:0] acc_q, acc_d, acc_src, acc_next;
    logic         sat_q, sat_d, acc_ovf;
    logic [1:0]   qtype_q, qtype_d;
    logic [7:0]   qbyte_q, qbyte_d;
    logic         tok_vld_d, tok_sat_d, ovf_d;
    logic [1:0]   tok_type_d;
    logic [W-1:0] tok_data_d;
    logic         accept, busy, take;

    assign accept  = tok_vld & tok_rdy;
    assign busy    = (tok_vld & ~tok_rdy) | (state_q == S_PEND);
    assign take    = rx_vld & ~busy;
    assign cls     = classify(rx_data);
    assign acc_src = (state_q == S_NUM) ? acc_q : '0;

    dec_acc #(.W(W)) u_dec_acc (
        .acc      (acc_src),
        .digit    (rx_data[3:0]),
        .acc_next (acc_next),
        .ovf      (acc_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_NUM: begin
                if (take) begin
                    unique case (cls)
                        CLS_DIGIT:        state_d = S_NUM;
                        CLS_OP, CLS_TERM: state_d = (state_q == S_NUM) ? S_PEND : S_IDLE;
                        default:          state_d = S_IDLE;
                    endcase
                end
            end
            S_PEND:  if (accept) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tok_vld_d  = tok_vld & ~accept;
        tok_type_d = tok_type;
        tok_data_d = tok_data;
        tok_sat_d  = tok_sat;
        acc_d      = acc_q;
        sat_d      = sat_q;
        qtype_d    = qtype_q;
        qbyte_d    = qbyte_q;
        ovf_d      = ovf | (rx_vld & busy);
        if (state_q == S_PEND && accept) begin
            tok_vld_d  = 1'b1;
            tok_type_d = qtype_q;
            tok_data_d = W'(qbyte_q);
            tok_sat_d  = 1'b0;
        end else if (take) begin
            if (cls == CLS_DIGIT) begin
                acc_d = acc_next;
                sat_d = ((state_q == S_NUM) & sat_q) | acc_ovf;
            end else if (state_q == S_NUM && cls != CLS_OTHER) begin
                // Operand ends: present it now, park any operator/terminator behind it
                tok_vld_d  = 1'b1;
                tok_type_d = TOK_NUM;
                tok_data_d = acc_q;
                tok_sat_d  = sat_q;
                acc_d      = '0;
                sat_d      = 1'b0;
                qtype_d    = (cls == CLS_OP) ? TOK_OP : TOK_EQ;
                qbyte_d    = (cls == CLS_OP) ? rx_data : 8'h00;
            end else if (cls == CLS_OP || cls == CLS_TERM) begin
                tok_vld_d  = 1'b1;
                tok_type_d = (cls == CLS_OP) ? TOK_OP : TOK_EQ;
                tok_data_d = (cls == CLS_OP) ? W'(rx_data) : '0;
                tok_sat_d  = 1'b0;
            end else if (cls == CLS_OTHER) begin
                tok_vld_d  = 1'b1;
                tok_type_d = TOK_ERR;
                tok_data_d = W'(rx_data);
                tok_sat_d  = 1'b0;
                acc_d      = '0;
                sat_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_vld  <= 1'b0;
            tok_type <= TOK_NUM;
            tok_data <= '0;
            tok_sat  <= 1'b0;
            ovf      <= 1'b0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            qtype_q  <= TOK_NUM;
            qbyte_q  <= 8'h00;
        end else begin
            tok_vld  <= tok_vld_d;
            tok_type <= tok_type_d;
            tok_data <= tok_data_d;
            tok_sat  <= tok_sat_d;
            ovf      <= ovf_d;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
            qtype_q  <= qtype_d;
            qbyte_q  <= qbyte_d;
        end
    end

endmodule

// File: tb/tb_calc_token_parser.sv
// Bench for calc_token_parser (W=32): vector table, timing sequences and random streams
// checked against a string-level tokenizer model. Honours CALC_PARSE_SAT_EN.
module tb_calc_token_parser;

    localparam int unsigned W = 32;
    localparam logic [1:0] T_NUM = 2'd0;
    localparam logic [1:0] T_OP  = 2'd1;
    localparam logic [1:0] T_EQ  = 2'd2;
    localparam logic [1:0] T_ERR = 2'd3;
    localparam longint unsigned MAXW = 64'hFFFF_FFFF;
`ifdef CALC_PARSE_SAT_EN
    localparam bit SAT_MODE = 1'b1;
`else
    localparam bit SAT_MODE = 1'b0;
`endif

    typedef logic [34:0] tok_t;  // {type, sat, data}
    typedef struct {
        string       s;
        int          n;
        tok_t [4:0]  t;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx_vld = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         tok_rdy = 1'b0;
    logic         tok_vld;
    logic [1:0]   tok_type;
    logic [W-1:0] tok_data;
    logic         tok_sat;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    tok_t got_q[$];
    tok_t exp_q[$];
    vec_t vecs[9];

    bit              m_in;
    longint unsigned m_val;
    bit              m_sat;

    calc_token_parser #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_vld   (rx_vld),
        .rx_data  (rx_data),
        .tok_vld  (tok_vld),
        .tok_rdy  (tok_rdy),
        .tok_type (tok_type),
        .tok_data (tok_data),
        .tok_sat  (tok_sat),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && tok_vld && tok_rdy) got_q.push_back({tok_type, tok_sat, tok_data});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic tok_t mk(logic [1:0] t, logic s, logic [31:0] d);
        return {t, s, d};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] b, int gap);
        rx_vld  = 1'b1;
        rx_data = b;
        step();
        rx_vld = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send_str(string s, int gap);
        for (int i = 0; i < s.len(); i++) send(s[i], gap);
    endtask

    task automatic compare_q(string name, int base);
        int n;
        check({name, " count"}, 64'(got_q.size() - base), 64'(exp_q.size()));
        n = (got_q.size() - base < exp_q.size()) ? got_q.size() - base : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s tok%0d", name, i), got_q[base + i], exp_q[i]);
    endtask

    task automatic wait_vld(string name);
        int n = 0;
        while (!tok_vld && n < 50) begin
            step();
            n++;
        end
        check({name, " tok_vld timeout"}, 64'(tok_vld), 64'd1);
    endtask

    // Hold the presented token for 20 cycles, checking it does not move, then accept it
    task automatic hold_accept(string name);
        tok_t snap;
        snap = {tok_type, tok_sat, tok_data};
        repeat (20) begin
            step();
            check({name, " stall"}, {tok_vld, tok_type, tok_sat, tok_data}, {1'b1, snap});
        end
        tok_rdy = 1'b1;
        step();
        tok_rdy = 1'b0;
    endtask

    // Reference tokenizer: one byte at a time, operand kept as a plain integer
    task automatic model_num();
        if (m_in) exp_q.push_back(mk(T_NUM, m_sat, m_val[31:0]));
        m_in = 1'b0;
    endtask

    task automatic model_byte(logic [7:0] b);
        if (b >= "0" && b <= "9") begin
            if (!m_in) begin
                m_val = 0;
                m_sat = 1'b0;
                m_in  = 1'b1;
            end
            m_val = m_val * 10 + longint'(b - 8'h30);
            if (m_val > MAXW) begin
                m_sat = 1'b1;
                m_val = SAT_MODE ? MAXW : (m_val & MAXW);
            end
        end else if (b == "+" || b == "-" || b == "*" || b == "/") begin
            model_num();
            exp_q.push_back(mk(T_OP, 1'b0, {24'h0, b}));
        end else if (b == "=" || b == 8'h0D) begin
            model_num();
            exp_q.push_back(mk(T_EQ, 1'b0, 32'h0));
        end else if (b == " " || b == 8'h0A) begin
            model_num();
        end else begin
            m_in = 1'b0;
            exp_q.push_back(mk(T_ERR, 1'b0, {24'h0, b}));
        end
    endtask

    task automatic send_rand(logic [7:0] b);
        rx_vld  = 1'b1;
        rx_data = b;
        tok_rdy = 1'($urandom_range(0, 1));
        step();
        rx_vld = 1'b0;
        for (int i = 1; i < 12; i++) begin
            tok_rdy = (i < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
    endtask

    task automatic set_vec(int i, string s, int n, tok_t a, tok_t b, tok_t c, tok_t d, tok_t e);
        vecs[i].s = s;
        vecs[i].n = n;
        vecs[i].t[0] = a;
        vecs[i].t[1] = b;
        vecs[i].t[2] = c;
        vecs[i].t[3] = d;
        vecs[i].t[4] = e;
    endtask

    task automatic check_reset_outputs(string name);
        check(name, {tok_vld, tok_type, tok_data, tok_sat, ovf}, '0);
    endtask

    initial begin
        tok_t z;
        logic [31:0] big1, big2;
        int base;
        z    = '0;
        big1 = SAT_MODE ? 32'hFFFF_FFFF : 32'h0000_0000;
        big2 = SAT_MODE ? 32'hFFFF_FFFF : 32'h4876_E7FF;
        set_vec(0, "12+3=", 4, mk(T_NUM, 0, 12), mk(T_OP, 0, 32'h2B), mk(T_NUM, 0, 3),
                mk(T_EQ, 0, 0), z);
        set_vec(1, "4x5=", 3, mk(T_ERR, 0, 32'h78), mk(T_NUM, 0, 5), mk(T_EQ, 0, 0), z, z);
        set_vec(2, "+= \n", 2, mk(T_OP, 0, 32'h2B), mk(T_EQ, 0, 0), z, z, z);
        set_vec(3, "0099\r", 2, mk(T_NUM, 0, 99), mk(T_EQ, 0, 0), z, z, z);
        set_vec(4, "4294967295 ", 1, mk(T_NUM, 0, 32'hFFFF_FFFF), z, z, z, z);
        set_vec(5, "4294967296 ", 1, mk(T_NUM, 1, big1), z, z, z, z);
        set_vec(6, "99999999999 ", 1, mk(T_NUM, 1, big2), z, z, z, z);
        set_vec(7, "9*7-/", 5, mk(T_NUM, 0, 9), mk(T_OP, 0, 32'h2A), mk(T_NUM, 0, 7),
                mk(T_OP, 0, 32'h2D), mk(T_OP, 0, 32'h2F));
        set_vec(8, "12a", 1, mk(T_ERR, 0, 32'h61), z, z, z, z);

        // Reset state
        repeat (3) step();
        check_reset_outputs("reset outputs");
        rst = 1'b0;
        step();
        check_reset_outputs("post-reset outputs");

        // Vector table, evaluator always ready
        tok_rdy = 1'b1;
        foreach (vecs[v]) begin
            base = got_q.size();
            exp_q.delete();
            for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(vecs[v].t[k]);
            send_str(vecs[v].s, 3);
            repeat (3) step();
            compare_q($sformatf("vec%0d", v), base);
        end
        check("ovf after table", 64'(ovf), 64'd0);

        // NUM/OP and NUM/EQ presented back-to-back
        send_str("12", 2);
        send("+", 0);
        @(negedge clk);
        check("b2b num", {tok_vld, tok_type, tok_data}, {1'b1, T_NUM, 32'd12});
        @(negedge clk);
        check("b2b op", {tok_vld, tok_type, tok_data}, {1'b1, T_OP, 32'h2B});
        @(negedge clk);
        check("b2b idle", 64'(tok_vld), 64'd0);
        step();
        send("3", 2);
        send("=", 0);
        @(negedge clk);
        check("b2b num3", {tok_vld, tok_type, tok_data}, {1'b1, T_NUM, 32'd3});
        @(negedge clk);
        check("b2b eq", {tok_vld, tok_type, tok_data}, {1'b1, T_EQ, 32'd0});
        step();

        // "7*8 " with 20-cycle stall on each token
        tok_rdy = 1'b0;
        base = got_q.size();
        exp_q.delete();
        exp_q.push_back(mk(T_NUM, 0, 7));
        exp_q.push_back(mk(T_OP, 0, 32'h2A));
        exp_q.push_back(mk(T_NUM, 0, 8));
        send("7", 2);
        send("*", 1);
        wait_vld("stall num7");
        hold_accept("stall num7");
        wait_vld("stall op");
        hold_accept("stall op");
        repeat (2) step();
        send("8", 2);
        send(" ", 1);
        wait_vld("stall num8");
        hold_accept("stall num8");
        repeat (3) step();
        compare_q("stall", base);
        check("ovf after stall", 64'(ovf), 64'd0);

        // Random streams against the reference model
        base = got_q.size();
        exp_q.delete();
        m_in = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic [7:0] b;
            int r;
            r = $urandom_range(0, 19);
            if (n == 299)      b = " ";
            else if (r < 10)   b = 8'h30 + 8'(r);
            else if (r == 10)  b = "+";
            else if (r == 11)  b = "-";
            else if (r == 12)  b = "*";
            else if (r == 13)  b = "/";
            else if (r == 14)  b = "=";
            else if (r == 15)  b = 8'h0D;
            else if (r == 16)  b = 8'h0A;
            else if (r == 17)  b = 8'($urandom_range(0, 255));
            else               b = " ";
            model_byte(b);
            send_rand(b);
        end
        tok_rdy = 1'b0;
        compare_q("random", base);
        check("ovf after random", 64'(ovf), 64'd0);

        // Byte arriving during a stall is dropped and ovf sticks
        base = got_q.size();
        exp_q.delete();
        exp_q.push_back(mk(T_OP, 0, 32'h2B));
        send("+", 2);
        send("9", 2);
        check("drop ovf set", 64'(ovf), 64'd1);
        tok_rdy = 1'b1;
        step();
        send(" ", 3);
        compare_q("drop", base);
        check("drop ovf sticky", 64'(ovf), 64'd1);

        // Reset mid-operand
        send_str("12", 2);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async reset outputs");
        repeat (2) step();
        check_reset_outputs("held reset outputs");
        rst = 1'b0;
        step();
        base = got_q.size();
        exp_q.delete();
        exp_q.push_back(mk(T_NUM, 0, 5));
        exp_q.push_back(mk(T_EQ, 0, 0));
        send_str("5=", 3);
        repeat (3) step();
        compare_q("after reset", base);
        check("ovf after reset", 64'(ovf), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
